// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined bitwise logic unit.
package logic_unit_pkg;

    localparam int LOGIC_OP_W = 3;

    typedef enum logic [LOGIC_OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_ANDN  = 3'd6,
        OP_PASSA = 3'd7
    } logic_op_t;

endpackage

// File: rtl/logic_pipe_stage.sv
// One elastic pipeline register: a valid bit plus a payload word.
// The payload is captured only when a real op moves in, so bubbles
// and flushes leave the previous contents untouched.
module logic_pipe_stage
    import logic_unit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         load,
    input  logic         d_valid,
    input  logic [W-1:0] d_data,
    output logic         q_valid,
    output logic [W-1:0] q_data
);

    // Valid bit: flush wins over load; a held stage keeps its valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid <= 1'b0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (load) begin
            q_valid <= d_valid;
        end
    end

    // Payload: captured only when a valid op actually enters the stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_data <= '0;
        end else if (load && d_valid && !flush) begin
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: op mux and flags feed a chain of STAGES
// elastic registers with valid/ready handshaking and flush.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic [LOGIC_OP_W-1:0] op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      result,
    output logic                  zero,
    output logic                  negative,
    output logic                  overflow,
    output logic                  carryOut
);

    // Payload layout: {result, zero, negative}, so flags travel with their result.
    localparam int PW = WIDTH + 2;

    logic_op_t          op_sel;
    logic [WIDTH-1:0]   op_result;
    logic [PW-1:0]      stage_in;
    logic [STAGES-1:0]  v;
    logic [STAGES-1:0]  adv;
    logic [PW-1:0]      stage_q [STAGES];

    assign op_sel = logic_op_t'(op);

    // Bitwise operation select; every encoding is a defined op.
    always_comb begin
        op_result = A;
        case (op_sel)
            OP_AND:   op_result = A & B;
            OP_OR:    op_result = A | B;
            OP_XOR:   op_result = A ^ B;
            OP_NAND:  op_result = ~(A & B);
            OP_NOR:   op_result = ~(A | B);
            OP_XNOR:  op_result = ~(A ^ B);
            OP_ANDN:  op_result = A & ~B;
            OP_PASSA: op_result = A;
            default:  op_result = A;
        endcase
    end

    assign stage_in = {op_result, ~|op_result, op_result[WIDTH-1]};

    // A stage may advance when it or any stage downstream of it is empty,
    // or the output is being consumed (flattened form of the ready chain).
    for (genvar i = 0; i < STAGES; i++) begin : g_adv
        assign adv[i] = out_ready | ~(&v[STAGES-1:i]);
    end

    assign in_ready = adv[0] & ~flush;

    // Register chain: stage 0 takes the fresh op, later stages copy forward.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic          d_valid;
        logic [PW-1:0] d_data;

        if (i == 0) begin : g_first
            assign d_valid = in_valid & in_ready;
            assign d_data  = stage_in;
        end else begin : g_rest
            assign d_valid = v[i-1];
            assign d_data  = stage_q[i-1];
        end

        logic_pipe_stage #(.W(PW)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .load    (adv[i]),
            .d_valid (d_valid),
            .d_data  (d_data),
            .q_valid (v[i]),
            .q_data  (stage_q[i])
        );
    end

    assign out_valid = v[STAGES-1];
    assign result    = stage_q[STAGES-1][PW-1:2];
    assign zero      = stage_q[STAGES-1][1];
    assign negative  = stage_q[STAGES-1][0];
    assign overflow  = 1'b0;
    assign carryOut  = 1'b0;

endmodule
